candy_sram_port: RTL and testbench
==================================

CANDY_SRAM_PORT -- requirements
Module: candy_sram_port

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2: request-buffer entries, power of two, 2 or more.
REQ-002 SHALL have parameter TIMEOUT, default 16: maximum cycles to wait for read data before an error response.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid, input, 1 bit: requester offers a request.
REQ-006 SHALL have port req_ready, output, 1 bit: request accepted when req_valid and req_ready are both high.
REQ-007 SHALL have port req_we, input, 1 bit: 1 means write, 0 means read.
REQ-008 SHALL have port req_addr, input, `SRAMAddrWidth (17 bits): SRAM word address.
REQ-009 SHALL have port req_wdata, input, `SRAMDataWidth (24 bits): write data.
REQ-010 SHALL have port resp_valid, output, 1 bit: response available.
REQ-011 SHALL have port resp_ready, input, 1 bit: requester consumes the response.
REQ-012 SHALL have port resp_rdata, output, 24 bits: read data; 0 for writes and errors.
REQ-013 SHALL have port resp_err, output, 1 bit: read timed out.
REQ-014 SHALL have port sram_write_enable, output, 1 bit: one-cycle SRAM write strobe.
REQ-015 SHALL have port sram_waddr, output, 17 bits, and port sram_wdata, output, 24 bits: SRAM write address and data.
REQ-016 SHALL have port sram_read_enable, output, 1 bit: SRAM read request, level.
REQ-017 SHALL have port sram_raddr, output, 17 bits: SRAM read address.
REQ-018 SHALL have port sram_rdata, input, 24 bits, and port sram_rdata_ready, input, 1 bit: SRAM read data and its valid flag.

Function
REQ-019 SHALL buffer accepted requests in an in-order FIFO; req_ready = !full, independent of pops in the same cycle.
REQ-020 SHALL run FSM states IDLE, WRITE, READ, RESP; only one SRAM operation outstanding at any time.
REQ-021 IDLE: SHALL pop the FIFO head when the FIFO is not empty and go to WRITE (req_we=1) or READ (req_we=0) next cycle; a request arriving in an empty FIFO starts no earlier than the cycle after acceptance.
REQ-022 WRITE: SHALL assert sram_write_enable for exactly 1 cycle with sram_waddr/sram_wdata from the popped entry, then go to RESP with resp_rdata=0 and resp_err=0.
REQ-023 READ: SHALL hold sram_read_enable=1 and sram_raddr stable until sram_rdata_ready=1, capture sram_rdata into resp_rdata, set resp_err=0, deassert read_enable the next cycle, and go to RESP.
REQ-024 READ timeout: SHALL use a wait counter cleared on READ entry; if sram_rdata_ready is still low after TIMEOUT cycles, SHALL go to RESP with resp_err=1 and resp_rdata=0, and SHALL ignore late sram_rdata_ready.
REQ-025 RESP: SHALL hold resp_valid=1 with resp_rdata/resp_err stable until resp_ready=1, then return to IDLE; a new head SHALL be popped no earlier than the next cycle.
REQ-026 SHALL never assert sram_write_enable and sram_read_enable in the same cycle.
REQ-027 SHALL treat sram_rdata_ready outside READ as don't-care.
REQ-028 SHALL let the FIFO accept new requests while the FSM is busy; a push and a pop in the same cycle SHALL leave the count unchanged.
REQ-029 Minimum latency from request acceptance to resp_valid: write 3 cycles; read 3 cycles plus SRAM delay.

Reset
REQ-030 On rst=0, SHALL asynchronously enter IDLE, empty the FIFO, clear the wait counter, and drive all outputs to 0, except req_ready, which goes to 1 after reset is released.
REQ-031 Reset mid-operation SHALL drop the in-flight request and all buffered requests with no response issued.

Structure
REQ-032 SRAMAddrWidth, SRAMDataWidth, RstEnable/RstDisable, and the FSM state encodings SHALL live in candy_defines.v.
REQ-033 The request buffer SHALL be sub-module candy_req_fifo, with push/pop/full/empty and a 42-bit entry {we, addr, wdata}.

Verification
REQ-034 Write: req write addr 0x00005 data 0x001234 -> one sram_write_enable pulse with waddr 0x00005 / wdata 0x001234; resp_valid with rdata 0, err 0.
REQ-035 Read: read addr 0x00005, SRAM returns 0x001234 after 2 cycles -> read_enable held 2 cycles; response rdata 0x001234, err 0.
REQ-036 Backpressure: 3 back-to-back requests, resp_ready low for 5 cycles -> req_ready low after 2 are buffered; responses in order with no loss.
REQ-037 Timeout: read with sram_rdata_ready held 0 -> after 16 cycles, resp_err=1 and rdata=0; a later rdata_ready pulse is ignored.
REQ-038 Reset during READ with 1 entry queued -> all outputs 0 immediately; after release, no response and FIFO empty.

Source files
------------

// File: rtl/candy_sram_port_pkg.sv
// Shared widths, reset levels, FSM encoding and request layout for the
// SRAM request port.
package candy_sram_port_pkg;

  localparam int SRAMAddrWidth = 17;
  localparam int SRAMDataWidth = 24;
  localparam int EntryWidth    = 1 + SRAMAddrWidth + SRAMDataWidth;

  localparam logic RstEnable  = 1'b0;
  localparam logic RstDisable = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Buffered request, packed as {we, addr, wdata}
  typedef struct packed {
    logic                     we;
    logic [SRAMAddrWidth-1:0] addr;
    logic [SRAMDataWidth-1:0] wdata;
  } req_t;

endpackage

// File: rtl/candy_sram_port_req_fifo.sv
// In-order request buffer. Depth must be a power of two so the pointers
// wrap naturally and the count MSB doubles as the full flag.
module candy_req_fifo
  import candy_sram_port_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = EntryWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               wr_ptr;
  logic [PW-1:0]               rd_ptr;
  logic [PW:0]                 count;
  logic                        do_push;
  logic                        do_pop;

  // Push is refused when full even if a pop happens in the same cycle
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = count[PW];
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy tracking; simultaneous push/pop keeps the count
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/candy_sram_port.sv
// Valid/ready request port in front of a single-ported SRAM. Requests are
// buffered in order and executed one at a time; every request yields one
// response, reads can time out with an error response.
module candy_sram_port
  import candy_sram_port_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [SRAMAddrWidth-1:0] req_addr,
  input  logic [SRAMDataWidth-1:0] req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [SRAMDataWidth-1:0] resp_rdata,
  output logic                     resp_err,
  output logic                     sram_write_enable,
  output logic [SRAMAddrWidth-1:0] sram_waddr,
  output logic [SRAMDataWidth-1:0] sram_wdata,
  output logic                     sram_read_enable,
  output logic [SRAMAddrWidth-1:0] sram_raddr,
  input  logic [SRAMDataWidth-1:0] sram_rdata,
  input  logic                     sram_rdata_ready
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  state_t                   state;
  state_t                   next_state;
  logic                     fifo_pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [EntryWidth-1:0]    fifo_dout;
  req_t                     head;
  logic [SRAMAddrWidth-1:0] cur_addr;
  logic [SRAMDataWidth-1:0] cur_wdata;
  logic [CW-1:0]            wait_cnt;
  logic                     timeout_hit;
  logic [SRAMDataWidth-1:0] rdata_q;
  logic                     err_q;

  candy_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EntryWidth)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_valid),
    .pop   (fifo_pop),
    .din   ({req_we, req_addr, req_wdata}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head        = req_t'(fifo_dout);
  // Held low during reset, then purely a function of buffer occupancy
  assign req_ready   = ~fifo_full & rst;
  assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) state <= ST_IDLE;
    else                  state <= next_state;
  end

  // Next-state: one SRAM operation at a time, always followed by RESP
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:  if (!fifo_empty) next_state = head.we ? ST_WRITE : ST_READ;
      ST_WRITE: next_state = ST_RESP;
      ST_READ:  if (sram_rdata_ready || timeout_hit) next_state = ST_RESP;
      ST_RESP:  if (resp_ready) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; buses are zero outside their active state
  always_comb begin
    fifo_pop          = 1'b0;
    sram_write_enable = 1'b0;
    sram_waddr        = '0;
    sram_wdata        = '0;
    sram_read_enable  = 1'b0;
    sram_raddr        = '0;
    resp_valid        = 1'b0;
    resp_rdata        = '0;
    resp_err          = 1'b0;
    unique case (state)
      ST_IDLE:  fifo_pop = ~fifo_empty;
      ST_WRITE: begin
        sram_write_enable = 1'b1;
        sram_waddr        = cur_addr;
        sram_wdata        = cur_wdata;
      end
      ST_READ: begin
        sram_read_enable = 1'b1;
        sram_raddr       = cur_addr;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
      end
      default: ;
    endcase
  end

  // Datapath: latch popped entry, count read wait cycles, build response.
  // Data arriving on the final wait cycle wins over the timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      cur_addr  <= '0;
      cur_wdata <= '0;
      wait_cnt  <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (fifo_pop) begin
        cur_addr  <= head.addr;
        cur_wdata <= head.wdata;
        wait_cnt  <= '0;
      end
      if (state == ST_WRITE) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
      if (state == ST_READ) begin
        if (sram_rdata_ready) begin
          rdata_q <= sram_rdata;
          err_q   <= 1'b0;
        end else if (timeout_hit) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_candy_sram_port.sv
// Bench for candy_sram_port: directed scenarios followed by random traffic,
// checked against an in-order transaction model and a behavioural SRAM.
module tb_candy_sram_port;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [16:0] req_addr;
  logic [23:0] req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [23:0] resp_rdata;
  logic        sram_write_enable, sram_read_enable;
  logic [16:0] sram_waddr, sram_raddr;
  logic [23:0] sram_wdata, sram_rdata;
  logic        sram_rdata_ready;

  candy_sram_port #(.FIFO_DEPTH(2), .TIMEOUT(TIMEOUT)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_we            (req_we),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .resp_valid        (resp_valid),
    .resp_ready        (resp_ready),
    .resp_rdata        (resp_rdata),
    .resp_err          (resp_err),
    .sram_write_enable (sram_write_enable),
    .sram_waddr        (sram_waddr),
    .sram_wdata        (sram_wdata),
    .sram_read_enable  (sram_read_enable),
    .sram_raddr        (sram_raddr),
    .sram_rdata        (sram_rdata),
    .sram_rdata_ready  (sram_rdata_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [16:0] addr; logic [23:0] data; int dly; } op_t;
  typedef struct { logic [23:0] rdata; logic err; } rsp_t;

  rsp_t        exp_q[$];
  op_t         wq[$];
  op_t         rq[$];
  logic [23:0] mdl_mem[int];
  logic [23:0] sram_mem[int];

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int force_dly = -1;
  int rcnt, cur_dly, acc_cyc, rise_cyc, rd_cycles, wr_cycles;
  int n_rv, n_we, n_re;
  logic [16:0] cur_raddr;
  logic in_read = 1'b0, prev_rv = 1'b0, acc = 1'b0, last_ready = 1'b1;

  logic        drv_valid = 1'b0, drv_we = 1'b0, drv_resp_ready = 1'b1;
  logic [16:0] drv_addr = '0;
  logic [23:0] drv_wdata = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int pick_dly();
    int r = $urandom_range(0, 9);
    if (r < 7) return $urandom_range(0, 3);
    if (r < 9) return $urandom_range(TIMEOUT - 2, TIMEOUT + 1);
    return 40;
  endfunction

  // One clock cycle: observe outputs, play the SRAM, drive the requester,
  // check responses and record accepted requests in the model.
  task automatic tick();
    rsp_t e;
    op_t  o;
    @(negedge clk); #1;
    if (sram_write_enable) begin
      n_we++; wr_cycles++;
      chk("wr_rd_overlap", sram_read_enable, 0);
      if (wq.size() == 0) chk("wr_spurious", 1, 0);
      else begin
        chk("waddr", sram_waddr, wq[0].addr);
        chk("wdata", sram_wdata, wq[0].data);
        void'(wq.pop_front());
      end
      sram_mem[int'(sram_waddr)] = sram_wdata;
    end
    if (sram_read_enable) begin
      rd_cycles++;
      if (!in_read) begin
        in_read = 1'b1; rcnt = 0; n_re++;
        if (rq.size() == 0) begin
          chk("rd_spurious", 1, 0); cur_dly = 0; cur_raddr = sram_raddr;
        end else begin
          cur_dly = rq[0].dly; cur_raddr = rq[0].addr; void'(rq.pop_front());
        end
      end
      chk("raddr", sram_raddr, cur_raddr);
      sram_rdata_ready = (rcnt == cur_dly);
      sram_rdata = sram_mem.exists(int'(sram_raddr)) ? sram_mem[int'(sram_raddr)] : 24'h0;
      rcnt++;
    end else begin
      in_read = 1'b0;
      sram_rdata_ready = 1'($urandom_range(0, 1));
      sram_rdata = 24'($urandom);
    end
    req_valid = drv_valid; req_we = drv_we; req_addr = drv_addr; req_wdata = drv_wdata;
    resp_ready = drv_resp_ready;
    last_ready = req_ready;
    if (resp_valid) begin
      n_rv++;
      if (!prev_rv) rise_cyc = cyc;
      if (exp_q.size() == 0) chk("resp_spurious", 1, 0);
      else begin
        chk("resp_rdata", resp_rdata, exp_q[0].rdata);
        chk("resp_err", resp_err, exp_q[0].err);
        if (resp_ready) void'(exp_q.pop_front());
      end
    end
    prev_rv = resp_valid;
    acc = req_valid && req_ready;
    if (acc) begin
      acc_cyc = cyc;
      o.addr = req_addr; o.data = req_wdata; o.dly = 0;
      if (req_we) begin
        mdl_mem[int'(req_addr)] = req_wdata;
        e.rdata = 24'h0; e.err = 1'b0;
        wq.push_back(o);
      end else begin
        o.dly = (force_dly >= 0) ? force_dly : pick_dly();
        rq.push_back(o);
        if (o.dly >= TIMEOUT) begin e.rdata = 24'h0; e.err = 1'b1; end
        else begin
          e.rdata = mdl_mem.exists(int'(req_addr)) ? mdl_mem[int'(req_addr)] : 24'h0;
          e.err = 1'b0;
        end
      end
      exp_q.push_back(e);
    end
    cyc++;
  endtask

  task automatic send(input logic we, input logic [16:0] a, input logic [23:0] d);
    int n = 0;
    drv_valid = 1'b1; drv_we = we; drv_addr = a; drv_wdata = d;
    do begin tick(); n++; end while (!acc && n < 50);
    chk("send_accepted", acc, 1);
    drv_valid = 1'b0;
  endtask

  task automatic drain(input int lim);
    int n = 0;
    drv_valid = 1'b0; drv_resp_ready = 1'b1;
    while ((exp_q.size() != 0 || prev_rv) && n < lim) begin tick(); n++; end
    chk("drain_resp", exp_q.size(), 0);
    chk("drain_ops", wq.size() + rq.size(), 0);
  endtask

  task automatic zero_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_resp"}, {resp_valid, resp_err, resp_rdata}, 0);
    chk({tag, "_wr"}, {sram_write_enable, sram_waddr, sram_wdata}, 0);
    chk({tag, "_rd"}, {sram_read_enable, sram_raddr}, 0);
  endtask

  initial begin
    int k;
    logic saw_full;
    rst = 1'b0; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
    resp_ready = 0; sram_rdata = '0; sram_rdata_ready = 0;
    #12;
    zero_outputs("reset");
    @(negedge clk); rst = 1'b1; #1;
    chk("ready_after_reset", req_ready, 1);
    repeat (2) tick();

    // single write
    wr_cycles = 0;
    send(1'b1, 17'h00005, 24'h001234);
    drain(30);
    chk("wr_strobe_cycles", wr_cycles, 1);
    chk("wr_latency", rise_cyc - acc_cyc, 3);

    // read, data on second read cycle
    rd_cycles = 0; force_dly = 1;
    send(1'b0, 17'h00005, 24'h0);
    drain(30);
    chk("rd_enable_cycles", rd_cycles, 2);
    chk("rd_latency", rise_cyc - acc_cyc, 4);

    // read timeout, late ready pulses come from the SRAM model afterwards
    rd_cycles = 0; force_dly = 100;
    send(1'b0, 17'h00005, 24'h0);
    drain(60);
    chk("timeout_rd_cycles", rd_cycles, TIMEOUT);

    // data on the last allowed wait cycle still counts
    force_dly = TIMEOUT - 1;
    send(1'b0, 17'h00005, 24'h0);
    drain(60);

    // backpressure: responses stalled, buffer fills, order preserved
    force_dly = 0; drv_resp_ready = 1'b0; k = 0; saw_full = 1'b0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      if (c == 5) drv_resp_ready = 1'b1;
      drv_valid = 1'b1; drv_we = ~k[0];
      drv_addr = 17'h10 + 17'(k >> 1); drv_wdata = 24'hA00000 + 24'(k);
      tick();
      if (!last_ready) saw_full = 1'b1;
      if (acc) k++;
    end
    chk("bp_full_seen", saw_full, 1);
    chk("bp_accepted", k, 4);
    drain(80);

    // reset during a read with one request queued
    force_dly = 100;
    send(1'b0, 17'h00003, 24'h0);
    send(1'b1, 17'h00004, 24'h00BEEF);
    tick();
    chk("rst_mid_read", sram_read_enable, 1);
    rst = 1'b0; #1;
    zero_outputs("rst_mid");
    exp_q.delete(); wq.delete(); rq.delete(); in_read = 1'b0; prev_rv = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1; #1;
    chk("ready_after_mid_reset", req_ready, 1);
    n_rv = 0; n_we = 0; n_re = 0;
    repeat (30) tick();
    chk("post_rst_resp", n_rv, 0);
    chk("post_rst_writes", n_we, 0);
    chk("post_rst_reads", n_re, 0);
    force_dly = 0; rd_cycles = 0; wr_cycles = 0;
    send(1'b0, 17'h00007, 24'h0);
    drain(30);
    chk("post_rst_one_read", rd_cycles, 1);
    chk("post_rst_no_write", wr_cycles, 0);

    // random traffic
    force_dly = -1;
    for (int c = 0; c < 3000; c++) begin
      if (!drv_valid || acc) begin
        drv_valid = ($urandom_range(0, 2) != 0);
        drv_we    = 1'($urandom_range(0, 1));
        drv_addr  = 17'($urandom_range(0, 7));
        drv_wdata = 24'($urandom);
      end
      drv_resp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
